data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/cpu_pkg.sv | 18 +
 rtl/data_mem_arbiter_arb_pick.sv | 33 +++
 rtl/data_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    CORE,
    LOADER
  } req_id_t;

endpackage

// File: rtl/data_mem_arbiter_arb_pick.sv
// Combinational winner selection between core and loader requests.
// ARB_ROUND_ROBIN_EN selects alternation on contention; otherwise the core has fixed priority.
module arb_pick
  import cpu_pkg::*;
(
  input  logic    core_req,
  input  logic    ldr_req,
  input  req_id_t last_winner,
  output logic    valid,
  output req_id_t winner
);

  always_comb begin
    valid  = core_req | ldr_req;
    winner = CORE;
    if (core_req && ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_winner == CORE) ? LOADER : CORE;
`else
      winner = CORE;
`endif
    end else if (ldr_req) begin
      winner = LOADER;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority has no history; the port exists so both builds share one interface.
  logic w_unused_last;
  assign w_unused_last = (last_winner == LOADER);
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter (core, loader) in front of a single-port synchronous data memory.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of core priority.
module data_mem_arbiter #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  import cpu_pkg::*;

  // state  | meaning
  // IDLE   | waiting; sample requests and latch the winner's fields
  // ACCESS | drive memory from latched fields, pulse winner's gnt
  // RESP   | read only: return mem_rdata with winner's rvalid

  arb_state_t        r_state, w_next;
  req_id_t           r_winner, w_winner, w_last_winner;
  logic              w_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_take;

  assign w_take = (r_state == IDLE) && w_valid;

  arb_pick u_pick (
    .core_req    (core_req),
    .ldr_req     (ldr_req),
    .last_winner (w_last_winner),
    .valid       (w_valid),
    .winner      (w_winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t r_last_winner;

  // Reset to LOADER so the core wins the first contended grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_winner <= LOADER;
    end else if (w_take) begin
      r_last_winner <= w_winner;
    end
  end

  assign w_last_winner = r_last_winner;
`else
  assign w_last_winner = LOADER;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_winner <= CORE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_winner <= w_winner;
        r_we     <= (w_winner == CORE) ? core_we    : ldr_we;
        r_addr   <= (w_winner == CORE) ? core_addr  : ldr_addr;
        r_wdata  <= (w_winner == CORE) ? core_wdata : ldr_wdata;
      end
    end
  end

  // Outputs decode from the state register only, so async reset clears them at once.
  always_comb begin
    w_next      = r_state;
    core_gnt    = 1'b0;
    core_rvalid = 1'b0;
    core_rdata  = '0;
    ldr_gnt     = 1'b0;
    ldr_rvalid  = 1'b0;
    ldr_rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_valid) w_next = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (r_winner == CORE) core_gnt = 1'b1;
        else                  ldr_gnt  = 1'b1;
        w_next = r_we ? IDLE : RESP;
      end
      RESP: begin
        if (r_winner == CORE) begin
          core_rvalid = 1'b1;
          core_rdata  = mem_rdata;
        end else begin
          ldr_rvalid = 1'b1;
          ldr_rdata  = mem_rdata;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural synchronous memory.
module tb_data_mem_arbiter;
  import cpu_pkg::*;

  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ldr_req = 0, ldr_we = 0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_gnt, ldr_rvalid;
  logic [DW-1:0] ldr_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  typedef struct packed {
    req_id_t       id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          rv_q[$];
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            n_chk = 0;
  int            n_pass = 0;

  data_mem_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] all_outs();
    return {core_gnt, core_rvalid, core_rdata, ldr_gnt, ldr_rvalid, ldr_rdata,
            mem_en, mem_we, mem_addr, mem_wdata, busy};
  endfunction

  task automatic push_exp(input req_id_t id, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
    exp_t e;
    e.id = id; e.we = we; e.addr = a; e.wdata = wd;
    e.rdata = we ? '0 : ref_mem[a];
    if (we) ref_mem[a] = wd;
    exp_q.push_back(e);
  endtask

  task automatic drive(input req_id_t id, input logic rq, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (id == CORE) begin
      core_req = rq; core_we = we; core_addr = a; core_wdata = wd;
    end else begin
      ldr_req = rq; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
    end
  endtask

  task automatic wait_gnt(input req_id_t id, output bit got, output int lat);
    got = 0; lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock); #1;
      lat++;
      if ((id == CORE) ? core_gnt : ldr_gnt) got = 1;
    end
    chk("gnt_seen", got, 1);
  endtask

  // One complete transaction; field values are scrambled after the grant.
  task automatic do_req(input req_id_t id, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    bit got; int lat;
    push_exp(id, we, a, wd);
    drive(id, 1'b1, we, a, wd);
    wait_gnt(id, got, lat);
    chk("gnt_latency", lat, 1);
    chk("busy_access", busy, 1);
    drive(id, 1'b0, ~we, ~a, ~wd);
    @(posedge clock); #1;
    if (we) begin
      chk("busy_after_wr", busy, 0);
    end else begin
      chk("rvalid_latency", (id == CORE) ? core_rvalid : ldr_rvalid, 1);
      chk("busy_resp", busy, 1);
      @(posedge clock); #1;
      chk("busy_after_rd", busy, 0);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 0);
    rv_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    chk("one_gnt", {31'd0, core_gnt & ldr_gnt}, 0);
    chk("one_rvalid", {31'd0, core_rvalid & ldr_rvalid}, 0);
    if (core_gnt || ldr_gnt) begin
      chk("gnt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gnt_id", {core_gnt, ldr_gnt}, (e.id == CORE) ? 2'b10 : 2'b01);
        chk("mem_access", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, e.we, e.addr, e.wdata});
        if (!e.we) rv_q.push_back(e);
      end
    end
    if (core_rvalid || ldr_rvalid) begin
      chk("rvalid_expected", rv_q.size() != 0, 1);
      if (rv_q.size() != 0) begin
        e = rv_q.pop_front();
        chk("rvalid_id", {core_rvalid, ldr_rvalid}, (e.id == CORE) ? 2'b10 : 2'b01);
        chk("rdata", core_rvalid ? core_rdata : ldr_rdata, e.rdata);
        chk("resp_mem_en", mem_en, 0);
      end
    end
    if (!mem_en) chk("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 0);
    if (!core_rvalid) chk("core_rdata_zero", core_rdata, 0);
    if (!ldr_rvalid) chk("ldr_rdata_zero", ldr_rdata, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got; int lat, cnt, cnt_mem;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0; ref_mem[i] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outs_init", all_outs(), 0);
    reset_n = 1'b1;

    // Write then read back through the other port; first request right after release.
    do_req(CORE, 1'b1, 8'h03, 16'h0005);
    do_req(LOADER, 1'b0, 8'h03, 16'h0000);
    do_req(CORE, 1'b1, 8'hFF, 16'hFFFF);
    do_req(LOADER, 1'b1, 8'h00, 16'hA5A5);
    do_req(CORE, 1'b0, 8'h00, 16'h1234);
    do_req(LOADER, 1'b0, 8'hFF, 16'h0000);
    for (int i = 0; i < 8; i++)
      do_req($urandom_range(1) ? LOADER : CORE, 1'($urandom_range(1)),
             8'($urandom_range(15)), 16'($urandom));

    // Core pulses req only while the loader owns ACCESS: it must be dropped.
    push_exp(LOADER, 1'b0, 8'h03, 16'h0000);
    drive(LOADER, 1'b1, 1'b0, 8'h03, 16'h0000);
    wait_gnt(LOADER, got, lat);
    drive(LOADER, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(CORE, 1'b1, 1'b1, 8'h55, 16'hDEAD);
    @(posedge clock); #1;
    drive(CORE, 1'b0, 1'b0, 8'h00, 16'h0000);
    chk("ldr_rvalid_043", ldr_rvalid, 1);
    cnt = 0; cnt_mem = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      cnt += int'(core_gnt); cnt_mem += int'(mem_en);
    end
    chk("dropped_core_gnt", cnt, 0);
    chk("dropped_mem_en", cnt_mem, 0);
    do_req(CORE, 1'b0, 8'h55, 16'h0000);

    // Reset during RESP of a core read aborts it without a late rvalid.
    push_exp(CORE, 1'b0, 8'h03, 16'h0000);
    drive(CORE, 1'b1, 1'b0, 8'h03, 16'h0000);
    wait_gnt(CORE, got, lat);
    drive(CORE, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(posedge clock); #1;
    chk("in_resp", core_rvalid, 1);
    pulse_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      cnt += int'(core_rvalid);
    end
    chk("no_rvalid_after_rst", cnt, 0);
    do_req(CORE, 1'b0, 8'h03, 16'h0000);

    // Both requesters hold req for 8 grants, starting from a fresh reset.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) push_exp(CORE, 1'b1, 8'h10, 16'h1111);
      else            push_exp(LOADER, 1'b1, 8'h20, 16'h2222);
`else
      push_exp(CORE, 1'b1, 8'h10, 16'h1111);
`endif
    end
    drive(CORE, 1'b1, 1'b1, 8'h10, 16'h1111);
    drive(LOADER, 1'b1, 1'b1, 8'h20, 16'h2222);
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 8; i++) begin
      @(posedge clock); #1;
      if (core_gnt || ldr_gnt) cnt++;
      if (cnt == 8) begin
        drive(CORE, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(LOADER, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end
    chk("contended_grants", cnt, 8);
    drive(CORE, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(LOADER, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(posedge clock);
    #1;
    chk("final_idle", busy, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("rv_q_drained", rv_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
